rr_dispatcher: RTL

- 1:N round-robin distributor: one decoupled input stream, N decoupled output ports.
- Each output has a one-entry registered buffer.
- Opposite end of the N:1 round-robin arbiter: fans one producer out to N consumers with the same fairness rule.
- Used to spread work items across N identical workers.

---
 rtl/rr_dispatcher_pkg.sv | 12 +
 rtl/rr_dispatch_slot.sv | 37 +++
 rtl/rr_dispatcher.sv | 72 +++++++
 3 files changed

// File: rtl/rr_dispatcher_pkg.sv
// Shared constants and helpers for the round-robin dispatcher.
package rr_dispatcher_pkg;

  localparam int unsigned DefaultN = 4;
  localparam int unsigned DefaultW = 8;
  localparam int unsigned PtrReset = 0;

  function automatic int unsigned sel_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_dispatch_slot.sv
// One-entry output buffer: holds a word until its consumer takes it.
module rr_dispatch_slot
  import rr_dispatcher_pkg::*;
#(
  parameter int unsigned W = DefaultW
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         out_ready,
  output logic         can_accept,
  output logic         out_valid,
  output logic [W-1:0] out_bits
);

  logic         vld_q;
  logic [W-1:0] dat_q;

  // Free now, or the resident word leaves on this edge.
  assign can_accept = !vld_q || out_ready;
  assign out_valid  = vld_q && !reset;
  assign out_bits   = dat_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q <= 1'b0;
      dat_q <= '0;
    end else if (wr_en) begin
      vld_q <= 1'b1;
      dat_q <= wr_data;
    end else if (vld_q && out_ready) begin
      vld_q <= 1'b0;
    end
  end

endmodule

// File: rtl/rr_dispatcher.sv
// 1:N round-robin distributor feeding N one-entry output buffers.
module rr_dispatcher
  import rr_dispatcher_pkg::*;
#(
  parameter int unsigned N = DefaultN,
  parameter int unsigned W = DefaultW,
  localparam int unsigned SELW = sel_width(N)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                io_in_valid,
  output logic                io_in_ready,
  input  logic [W-1:0]        io_in_bits,
  output logic [N-1:0]        io_out_valid,
  input  logic [N-1:0]        io_out_ready,
  output logic [N-1:0][W-1:0] io_out_bits,
  output logic [SELW-1:0]     io_chosen
);

  logic [SELW-1:0] ptr_q;
  logic [N-1:0]    can;
  logic [N-1:0]    wr_en;
  logic            in_fire;
  logic            found;

  // Search ports above the last grant first, then wrap to the low ports.
  always_comb begin
    found     = 1'b0;
    io_chosen = SELW'(N - 1);
    for (int i = 0; i < N; i++) begin
      if (!found && (i > int'(ptr_q)) && can[i]) begin
        io_chosen = SELW'(i);
        found     = 1'b1;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!found && (i <= int'(ptr_q)) && can[i]) begin
        io_chosen = SELW'(i);
        found     = 1'b1;
      end
    end
  end

  assign io_in_ready = |can;
  assign in_fire     = io_in_valid && io_in_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= SELW'(PtrReset);
    end else if (in_fire) begin
      ptr_q <= io_chosen;
    end
  end

  for (genvar g = 0; g < N; g++) begin : gen_slot
    assign wr_en[g] = in_fire && (io_chosen == SELW'(g));

    rr_dispatch_slot #(
      .W(W)
    ) u_slot (
      .clk       (clk),
      .reset     (reset),
      .wr_en     (wr_en[g]),
      .wr_data   (io_in_bits),
      .out_ready (io_out_ready[g]),
      .can_accept(can[g]),
      .out_valid (io_out_valid[g]),
      .out_bits  (io_out_bits[g])
    );
  end

endmodule
